uart_buffered: RTL and testbench

Buffered UART for the LM32 SoC peripheral bus side and for testbench communication partners. Generalises the plain UART with parametrised receive/transmit FIFO depth, optional even/odd parity, 16x oversampled receive, and explicit framing, parity and overflow reporting. It sits between the Wishbone UART register wrapper, or a bench driver task, and the board uart_rxd/uart_txd pins.

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_buffered.sv | 211 +++++++++++++++++++++
 tb/tb_uart_buffered.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the buffered UART.
package uart_pkg;
    localparam int OVERSAMPLE = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a push is still honoured when full
// if a pop happens in the same cycle.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  logic [width-1:0]        i_wr_data,
    input  logic                    i_pop,
    output logic [width-1:0]        o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(depth):0]  o_count
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] r_mem [depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(depth));
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: storage is deliberately not reset; only pointers and count are, and an
    // empty FIFO masks the head to zero, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: 16x oversampled receiver and transmitter, each behind a FIFO,
// with optional even/odd parity and one-cycle error/overflow pulses.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int freq_hz     = 50000000,
    parameter int baud        = 115200,
    parameter int fifo_depth  = 16,
    parameter int parity_mode = PAR_NONE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         uart_rxd,
    output logic                         uart_txd,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_wr,
    output logic                         tx_full,
    output logic                         tx_busy,
    output logic [7:0]                   rx_data,
    output logic                         rx_avail,
    input  logic                         rx_ack,
    output logic                         rx_error,
    output logic                         rx_overflow,
    output logic [$clog2(fifo_depth):0]  rx_count
);
    localparam int DIV     = freq_hz / (baud * OVERSAMPLE);
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_CYC = DIV * OVERSAMPLE;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic PAR_ON  = (parity_mode != PAR_NONE);
    localparam logic PAR_INV = (parity_mode == PAR_ODD);

    logic [TW-1:0] r_tick_cnt;
    logic          w_tick16;

    logic          r_rxd_meta, r_rxd_sync, r_rxd_prev;
    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic [3:0]    r_rx_phase;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_par_err, r_rx_error, r_rx_overflow;
    logic          w_rx_fall, w_rx_sample, w_rx_good, w_rx_bad;
    logic          w_rx_full, w_rx_empty;

    tx_state_t     r_tx_state, w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx_par, r_txd;
    logic          w_tx_bit_end, w_tx_pop, w_txd_nxt, w_tx_empty;
    logic [7:0]    w_tx_head;
    logic [$clog2(fifo_depth):0] w_tx_count;

    assign w_tick16 = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= w_tick16 ? '0 : r_tick_cnt + TW'(1);
    end

    assign w_rx_fall   = r_rxd_prev && !r_rxd_sync;
    assign w_rx_sample = w_tick16 && (r_rx_phase == 4'd15);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_good      = 1'b0;
        w_rx_bad       = 1'b0;
        case (r_rx_state)
            R_IDLE:   if (w_rx_fall) w_rx_state_nxt = R_START;
            R_START:  if (w_tick16 && r_rx_phase == 4'd7)
                          w_rx_state_nxt = r_rxd_sync ? R_IDLE : R_DATA;
            R_DATA:   if (w_rx_sample && r_rx_bit == 3'd7)
                          w_rx_state_nxt = PAR_ON ? R_PARITY : R_STOP;
            R_PARITY: if (w_rx_sample) w_rx_state_nxt = R_STOP;
            R_STOP:   if (w_rx_sample) begin
                          w_rx_state_nxt = R_IDLE;
                          w_rx_bad  = !r_rxd_sync || r_rx_par_err;
                          w_rx_good = r_rxd_sync && !r_rx_par_err;
                      end
            default:  w_rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta    <= 1'b1;
            r_rxd_sync    <= 1'b1;
            r_rxd_prev    <= 1'b1;
            r_rx_state    <= R_IDLE;
            r_rx_phase    <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_par_err  <= 1'b0;
            r_rx_error    <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
            r_rx_state <= w_rx_state_nxt;
            // START re-zeroes the phase at mid start bit so later samples land mid-bit.
            if (r_rx_state == R_IDLE)
                r_rx_phase <= '0;
            else if (w_tick16)
                r_rx_phase <= (r_rx_state == R_START && r_rx_phase == 4'd7) ? 4'd0 : r_rx_phase + 4'd1;
            if (r_rx_state == R_START) begin
                r_rx_bit     <= '0;
                r_rx_par_err <= 1'b0;
            end
            if (r_rx_state == R_DATA && w_rx_sample) begin
                r_rx_shift <= {r_rxd_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (r_rx_state == R_PARITY && w_rx_sample)
                r_rx_par_err <= ((^r_rx_shift) ^ r_rxd_sync) != PAR_INV;
            r_rx_error    <= w_rx_bad;
            r_rx_overflow <= w_rx_good && w_rx_full && !rx_ack;
        end
    end

    sync_fifo #(.width(8), .depth(fifo_depth)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_rx_good),
        .i_wr_data (r_rx_shift),
        .i_pop     (rx_ack),
        .o_rd_data (rx_data),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty),
        .o_count   (rx_count)
    );

    assign rx_avail    = !w_rx_empty;
    assign rx_error    = r_rx_error;
    assign rx_overflow = r_rx_overflow;

    sync_fifo #(.width(8), .depth(fifo_depth)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (tx_wr),
        .i_wr_data (tx_data),
        .i_pop     (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_full    (tx_full),
        .o_empty   (w_tx_empty),
        .o_count   (w_tx_count)
    );

    assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_pop       = 1'b0;
        w_txd_nxt      = 1'b1;
        case (r_tx_state)
            T_IDLE:   if (!w_tx_empty) begin
                          w_tx_pop       = 1'b1;
                          w_tx_state_nxt = T_START;
                      end
            T_START:  begin
                          w_txd_nxt = 1'b0;
                          if (w_tx_bit_end) w_tx_state_nxt = T_DATA;
                      end
            T_DATA:   begin
                          w_txd_nxt = r_tx_shift[0];
                          if (w_tx_bit_end && r_tx_bit == 3'd7)
                              w_tx_state_nxt = PAR_ON ? T_PARITY : T_STOP;
                      end
            T_PARITY: begin
                          w_txd_nxt = r_tx_par;
                          if (w_tx_bit_end) w_tx_state_nxt = T_STOP;
                      end
            T_STOP:   if (w_tx_bit_end) begin
                          w_tx_pop       = !w_tx_empty;
                          w_tx_state_nxt = w_tx_empty ? T_IDLE : T_START;
                      end
            default:  w_tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= T_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_txd      <= w_txd_nxt;
            r_tx_cnt   <= (r_tx_state == T_IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + CW'(1);
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_par   <= (^w_tx_head) ^ PAR_INV;
                r_tx_bit   <= '0;
            end else if (r_tx_state == T_DATA && w_tx_bit_end) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end
    end

    assign uart_txd = r_txd;
    assign tx_busy  = (w_tx_count != '0) || (r_tx_state != T_IDLE);
endmodule

// File: tb/tb_uart_buffered.sv
// Bench for uart_buffered: a loopback instance (no parity) and a directly
// driven even-parity instance, both at 50 MHz / 115200 baud with 4-entry FIFOs.
module tb_uart_buffered;
    localparam int BIT = 432;  // 16 * (50e6 / (115200*16))

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // line[k] = k-th bit on the wire: start, d0..d7, stop
    } frame_vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst0, rst1;
    logic       txd0, txd1, rxd1;
    logic [7:0] tx_data0, tx_data1, rx_data0, rx_data1;
    logic       tx_wr0, tx_wr1, tx_full0, tx_full1, tx_busy0, tx_busy1;
    logic       rx_avail0, rx_avail1, rx_ack0, rx_ack1;
    logic       rx_error0, rx_error1, rx_overflow0, rx_overflow1;
    logic [2:0] rx_count0, rx_count1;

    uart_buffered #(.freq_hz(50000000), .baud(115200), .fifo_depth(4), .parity_mode(0)) u_dut0 (
        .clk(clk), .reset(rst0), .uart_rxd(txd0), .uart_txd(txd0),
        .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0), .tx_busy(tx_busy0),
        .rx_data(rx_data0), .rx_avail(rx_avail0), .rx_ack(rx_ack0),
        .rx_error(rx_error0), .rx_overflow(rx_overflow0), .rx_count(rx_count0)
    );

    uart_buffered #(.freq_hz(50000000), .baud(115200), .fifo_depth(4), .parity_mode(1)) u_dut1 (
        .clk(clk), .reset(rst1), .uart_rxd(rxd1), .uart_txd(txd1),
        .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1), .tx_busy(tx_busy1),
        .rx_data(rx_data1), .rx_avail(rx_avail1), .rx_ack(rx_ack1),
        .rx_error(rx_error1), .rx_overflow(rx_overflow1), .rx_count(rx_count1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_err0  = 0;
    int n_err1  = 0;
    int n_ovf0  = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always @(posedge clk) begin
        n_err0 <= n_err0 + (rx_error0 ? 1 : 0);
        n_err1 <= n_err1 + (rx_error1 ? 1 : 0);
        n_ovf0 <= n_ovf0 + (rx_overflow0 ? 1 : 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write is taken at the following posedge.
    task automatic tx_write0(input logic [7:0] d);
        tx_data0 = d;
        tx_wr0   = 1'b1;
        @(negedge clk);
        tx_wr0   = 1'b0;
    endtask

    task automatic wait_fall0(output int lat);
        lat = 0;
        while (txd0 !== 1'b0 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Starts at the first negedge with the start bit on the line; samples mid-bit.
    task automatic capture0(input int n, output logic [63:0] bits);
        bits = '0;
        for (int k = 0; k < n; k++) begin
            repeat ((k == 0) ? BIT / 2 : BIT) @(negedge clk);
            bits[k] = txd0;
        end
    endtask

    task automatic wait_idle0(input int budget);
        int t = 0;
        while (tx_busy0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("tx_idle_timeout", tx_busy0, 1'b0);
    endtask

    task automatic pop_check(input int which, input string name);
        int t = 0;
        logic [7:0] exp;
        while (((which == 0) ? rx_avail0 : rx_avail1) !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_avail"}, (which == 0) ? rx_avail0 : rx_avail1, 1'b1);
        exp = (which == 0) ? q0.pop_front() : q1.pop_front();
        check(name, (which == 0) ? rx_data0 : rx_data1, exp);
        if (which == 0) rx_ack0 = 1'b1; else rx_ack1 = 1'b1;
        @(negedge clk);
        rx_ack0 = 1'b0;
        rx_ack1 = 1'b0;
    endtask

    task automatic drive_frame1(input logic [7:0] d, input logic par, input logic stop);
        rxd1 = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd1 = d[i];
            repeat (BIT) @(negedge clk);
        end
        rxd1 = par;
        repeat (BIT) @(negedge clk);
        rxd1 = stop;
        repeat (BIT) @(negedge clk);
        rxd1 = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    initial begin
        frame_vec_t  vecs[3];
        logic [7:0]  btb[4];
        logic [7:0]  ov[6];
        logic [63:0] bits;
        logic [63:0] exp_bits;
        int          lat;

        vecs[0] = '{data: 8'h55, line: 10'b1010101010};
        vecs[1] = '{data: 8'hA5, line: 10'b1101001010};
        vecs[2] = '{data: 8'h3C, line: 10'b1001111000};
        btb = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
        ov  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h77};

        rst0 = 1'b1; rst1 = 1'b1; rxd1 = 1'b1;
        tx_data0 = '0; tx_data1 = '0; tx_wr0 = 1'b0; tx_wr1 = 1'b0;
        rx_ack0 = 1'b0; rx_ack1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst0_flags", {txd0, tx_full0, tx_busy0, rx_avail0, rx_error0, rx_overflow0}, 6'b100000);
        check("rst0_data_count", {rx_data0, rx_count0}, 11'd0);
        check("rst1_flags", {txd1, tx_full1, tx_busy1, rx_avail1, rx_error1, rx_overflow1}, 6'b100000);
        check("rst1_data_count", {rx_data1, rx_count1}, 11'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (5) @(negedge clk);

        fork
            begin : loopback_thread
                int e0;
                int o0;
                int lows;
                e0 = n_err0;
                // Single frames from the table: latency, bit pattern, busy window, loopback byte.
                for (int i = 0; i < 3; i++) begin
                    q0.push_back(vecs[i].data);
                    tx_write0(vecs[i].data);              // now just after write edge N
                    check("busy_after_wr", tx_busy0, 1'b1);
                    wait_fall0(lat);
                    check("txd_fall_latency", lat, 2);    // txd low after edge N+2
                    capture0(10, bits);                   // ends just after edge N+4106
                    check("frame_bits", bits[9:0], vecs[i].line);
                    // Pop at N+1 starts 4320 cycles of frame; FSM is idle after edge N+4321.
                    repeat (4319 - 4106) @(negedge clk);
                    check("busy_last_cycle", tx_busy0, 1'b1);
                    repeat (3) @(negedge clk);
                    check("busy_dropped", tx_busy0, 1'b0);
                    pop_check(0, "loop_rx");
                end

                // Back-to-back frames: 40 consecutive bit slots prove there is no idle gap.
                foreach (btb[i]) q0.push_back(btb[i]);
                fork
                    begin
                        for (int i = 0; i < 4; i++) tx_write0(btb[i]);
                    end
                    begin
                        int l2;
                        wait_fall0(l2);
                        capture0(40, bits);
                    end
                join
                exp_bits = '0;
                for (int i = 0; i < 4; i++) exp_bits[10*i +: 10] = {1'b1, btb[i], 1'b0};
                check("btb_bits", bits, exp_bits);
                wait_idle0(2000);
                repeat (40) @(negedge clk);
                check("btb_rx_count_peak", rx_count0, 3'd4);
                for (int i = 0; i < 4; i++) pop_check(0, "btb_rx");
                check("btb_no_error", n_err0 - e0, 0);

                // Six bytes into a 4-deep RX FIFO that is never acked.
                o0 = n_ovf0;
                for (int i = 0; i < 4; i++) q0.push_back(ov[i]);
                for (int i = 0; i < 5; i++) tx_write0(ov[i]);
                check("tx_full_set", tx_full0, 1'b1);
                tx_write0(8'hEE);                         // dropped: FIFO full, no pop this cycle
                check("tx_full_hold", tx_full0, 1'b1);
                lat = 0;
                while (tx_full0 && lat < 6000) begin
                    @(negedge clk);
                    lat++;
                end
                check("tx_full_clear_timeout", tx_full0, 1'b0);
                tx_write0(ov[5]);
                wait_idle0(30000);
                repeat (100) @(negedge clk);
                check("ovf_rx_count", rx_count0, 3'd4);
                check("ovf_pulses", n_ovf0 - o0, 2);
                check("ovf_no_error", n_err0 - e0, 0);
                for (int i = 0; i < 4; i++) pop_check(0, "ovf_retained");
                rx_ack0 = 1'b1;                           // ack while empty is ignored
                @(negedge clk);
                rx_ack0 = 1'b0;
                check("ack_empty_count", {rx_avail0, rx_count0}, 4'd0);

                // Reset in the middle of a data bit with bytes still queued.
                for (int i = 0; i < 3; i++) tx_write0(8'hC3 ^ 8'(i));
                wait_fall0(lat);
                repeat (BIT / 2 + 2 * BIT) @(negedge clk);
                rst0 = 1'b1;
                @(negedge clk);
                check("rst_mid_flags", {txd0, tx_busy0, tx_full0, rx_avail0}, 4'b1000);
                check("rst_mid_rx_count", rx_count0, 3'd0);
                rst0 = 1'b0;
                lows = 0;
                for (int i = 0; i < 5000; i++) begin
                    @(negedge clk);
                    if (txd0 !== 1'b1 || tx_busy0 !== 1'b0) lows++;
                end
                check("rst_nothing_sent", lows, 0);
                check("rst_no_error", n_err0 - e0, 0);
            end

            begin : parity_thread
                int e1;
                e1 = n_err1;
                drive_frame1(8'h07, 1'b0, 1'b1);        // even parity of 0x07 is 1
                check("par_bad_err", n_err1 - e1, 1);
                check("par_bad_no_push", rx_avail1, 1'b0);
                q1.push_back(8'h07);
                drive_frame1(8'h07, 1'b1, 1'b1);
                check("par_good_no_err", n_err1 - e1, 1);
                pop_check(1, "par_good_rx");
                drive_frame1(8'h81, 1'b0, 1'b0);        // correct parity, stop bit low
                check("stop_low_err", n_err1 - e1, 2);
                check("stop_low_no_push", rx_count1, 3'd0);
                rxd1 = 1'b0;
                repeat (100) @(negedge clk);
                rxd1 = 1'b1;
                repeat (2 * BIT) @(negedge clk);
                check("glitch_no_err", n_err1 - e1, 2);
                check("glitch_no_push", rx_count1, 3'd0);
                q1.push_back(8'h5A);
                drive_frame1(8'h5A, 1'b0, 1'b1);        // receiver must be back in idle
                pop_check(1, "after_glitch_rx");
                check("after_glitch_no_err", n_err1 - e1, 2);
            end
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
